// File: rtl/wishbone_master_if_pkg.sv
// Shared Wishbone bus widths, bridge state encodings and the request payload type.
package wishbone_master_if_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  localparam logic [WB_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_BUSY  = 2'd1,
    WB_DONE  = 2'd2,
    WB_ABORT = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/wishbone_master_if_if.sv
// Classic single-beat Wishbone bus between the CPU bridge (master) and a slave.
interface wishbone_master_if_if;
  import wishbone_master_if_pkg::*;

  logic [WB_ADDR_W-1:0] wishbone_addr_o;
  logic [WB_DATA_W-1:0] wishbone_data_o;
  logic                 wishbone_we_o;
  logic [WB_SEL_W-1:0]  wishbone_sel_o;
  logic                 wishbone_stb_o;
  logic                 wishbone_cyc_o;
  logic [WB_DATA_W-1:0] wishbone_data_i;
  logic                 wishbone_ack_i;

  modport master (
    output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
    output wishbone_stb_o, wishbone_cyc_o,
    input  wishbone_data_i, wishbone_ack_i
  );

  modport slave (
    input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
    input  wishbone_stb_o, wishbone_cyc_o,
    output wishbone_data_i, wishbone_ack_i
  );

endinterface

// File: rtl/wishbone_master_if.sv
// Bridges one CPU load/store into a single-beat Wishbone cycle, with flush abort
// and a no-ack timeout; always leaves at least one idle bus cycle between requests.
module wishbone_master_if
  import wishbone_master_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [WB_ADDR_W-1:0] cpu_addr_i,
  input  logic [WB_SEL_W-1:0]  cpu_sel_i,
  input  logic [WB_DATA_W-1:0] cpu_data_i,
  input  logic                 cpu_flush_i,
  output logic [WB_DATA_W-1:0] cpu_data_o,
  output logic                 cpu_ready_o,
  output logic                 cpu_err_o,
  output logic                 cpu_stall_o,
  wishbone_master_if_if.master wb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  wb_state_e        state;
  logic [CNT_W-1:0] tmo_cnt;
  wb_req_t          req_c;

  always_comb begin
    req_c      = '0;
    req_c.addr = cpu_addr_i;
    req_c.data = cpu_data_i;
    req_c.we   = cpu_we_i;
    req_c.sel  = cpu_sel_i;
  end

  // Stall drops only in the completion cycle, or immediately on flush.
  assign cpu_stall_o = cpu_req_i & (state != WB_DONE) & ~cpu_flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WB_IDLE;
      tmo_cnt            <= '0;
      cpu_data_o         <= ZERO_WORD;
      cpu_ready_o        <= 1'b0;
      cpu_err_o          <= 1'b0;
      wb.wishbone_addr_o <= '0;
      wb.wishbone_data_o <= ZERO_WORD;
      wb.wishbone_we_o   <= 1'b0;
      wb.wishbone_sel_o  <= '0;
      wb.wishbone_stb_o  <= 1'b0;
      wb.wishbone_cyc_o  <= 1'b0;
    end else begin
      cpu_ready_o <= 1'b0;
      cpu_err_o   <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (cpu_req_i && !cpu_flush_i) begin
            wb.wishbone_addr_o <= req_c.addr;
            wb.wishbone_data_o <= req_c.data;
            wb.wishbone_we_o   <= req_c.we;
            wb.wishbone_sel_o  <= req_c.sel;
            wb.wishbone_stb_o  <= 1'b1;
            wb.wishbone_cyc_o  <= 1'b1;
            tmo_cnt            <= '0;
            state              <= WB_BUSY;
          end
        end
        WB_BUSY: begin
          // Flush wins over ack; a same-cycle acked write is still performed.
          if (cpu_flush_i) begin
            wb.wishbone_stb_o <= 1'b0;
            wb.wishbone_cyc_o <= 1'b0;
            state             <= WB_ABORT;
          end else if (wb.wishbone_ack_i) begin
            cpu_data_o        <= wb.wishbone_we_o ? ZERO_WORD : wb.wishbone_data_i;
            cpu_ready_o       <= 1'b1;
            wb.wishbone_stb_o <= 1'b0;
            wb.wishbone_cyc_o <= 1'b0;
            state             <= WB_DONE;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cpu_data_o        <= ZERO_WORD;
            cpu_ready_o       <= 1'b1;
            cpu_err_o         <= 1'b1;
            wb.wishbone_stb_o <= 1'b0;
            wb.wishbone_cyc_o <= 1'b0;
            state             <= WB_DONE;
          end else if (tmo_cnt != {CNT_W{1'b1}}) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        WB_DONE:  state <= WB_IDLE;
        WB_ABORT: state <= WB_IDLE;
        default:  state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master_if.sv
// Bench for wishbone_master_if: table of single transactions plus flush, back-to-back
// and reset sequences, with a completion scoreboard fed at request time.
module tb_wishbone_master_if;
  import wishbone_master_if_pkg::*;

  localparam int unsigned TMO = 8;

  typedef struct {
    logic        we;
    logic        dead;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned waits;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_flush;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_sel;
  logic        cpu_ready, cpu_err, cpu_stall;

  int checks   = 0;
  int failures = 0;
  exp_t sb_q[$];
  vec_t vecs[7];
  vec_t vb0, vb1, vfl;

  wishbone_master_if_if wb_bus();

  wishbone_master_if #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_sel_i   (cpu_sel),
    .cpu_data_i  (cpu_wdata),
    .cpu_flush_i (cpu_flush),
    .cpu_data_o  (cpu_rdata),
    .cpu_ready_o (cpu_ready),
    .cpu_err_o   (cpu_err),
    .cpu_stall_o (cpu_stall),
    .wb          (wb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: acks after slave_wait wait states, never when dead.
  int unsigned slave_wait;
  logic        slave_dead;
  logic [31:0] slave_rdata;
  int unsigned wcnt;

  assign wb_bus.wishbone_data_i = slave_rdata;

  always @(posedge clk) begin
    if (wb_bus.wishbone_cyc_o && wb_bus.wishbone_stb_o && !wb_bus.wishbone_ack_i && !slave_dead) begin
      if (wcnt == slave_wait) begin
        wb_bus.wishbone_ack_i <= 1'b1;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wb_bus.wishbone_ack_i <= 1'b0;
      if (!wb_bus.wishbone_cyc_o) wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cpu_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 128'(cpu_ready), 128'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ready_data", 128'(cpu_rdata), 128'(e.data));
        check("ready_err", 128'(cpu_err), 128'(e.err));
      end
    end
  end

  function automatic logic [104:0] all_outs();
    return {cpu_rdata, cpu_ready, cpu_err, wb_bus.wishbone_addr_o, wb_bus.wishbone_data_o,
            wb_bus.wishbone_we_o, wb_bus.wishbone_sel_o, wb_bus.wishbone_stb_o,
            wb_bus.wishbone_cyc_o};
  endfunction

  // Called at posedge+1; cycle 0 is the accept cycle, ready expected in cycle lat.
  task automatic run_txn(input vec_t v, input bit keep_req);
    int unsigned lat;
    logic [68:0] exp_bus;
    logic        in_bus;
    lat     = v.dead ? TMO + 1 : v.waits + 3;
    exp_bus = {v.addr, v.wdata, v.we, v.sel};
    slave_wait  = v.waits;
    slave_dead  = v.dead;
    slave_rdata = v.rdata;
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_sel   = v.sel;
    cpu_wdata = v.wdata;
    sb_q.push_back('{data: v.exp_data, err: v.exp_err});
    for (int unsigned c = 0; c <= lat; c++) begin
      @(negedge clk);
      in_bus = (c >= 1) && (c < lat);
      check("stall", 128'(cpu_stall), 128'(c != lat));
      check("ready_timing", 128'(cpu_ready), 128'(c == lat));
      check("cyc", 128'(wb_bus.wishbone_cyc_o), 128'(in_bus));
      check("stb", 128'(wb_bus.wishbone_stb_o), 128'(in_bus));
      if (in_bus)
        check("bus_hold", 128'({wb_bus.wishbone_addr_o, wb_bus.wishbone_data_o,
                                wb_bus.wishbone_we_o, wb_bus.wishbone_sel_o}), 128'(exp_bus));
      if (c != lat) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    if (!keep_req) cpu_req = 1'b0;
  endtask

  initial begin
    vecs[0] = '{we:1'b0, dead:1'b0, addr:32'h0000_0010, sel:4'hF, wdata:32'h0,
                rdata:32'hDEAD_BEEF, waits:0, exp_data:32'hDEAD_BEEF, exp_err:1'b0};
    vecs[1] = '{we:1'b1, dead:1'b0, addr:32'h0000_0004, sel:4'b0010, wdata:32'h0000_AB00,
                rdata:32'h1234_5678, waits:3, exp_data:32'h0, exp_err:1'b0};
    vecs[2] = '{we:1'b0, dead:1'b0, addr:32'h0000_0100, sel:4'b0001, wdata:32'h0,
                rdata:32'hCAFE_F00D, waits:1, exp_data:32'hCAFE_F00D, exp_err:1'b0};
    vecs[3] = '{we:1'b0, dead:1'b0, addr:32'h0000_0180, sel:4'hF, wdata:32'h0,
                rdata:32'h0BAD_CAFE, waits:TMO - 2, exp_data:32'h0BAD_CAFE, exp_err:1'b0};
    vecs[4] = '{we:1'b0, dead:1'b1, addr:32'h0000_0040, sel:4'hF, wdata:32'h0,
                rdata:32'h55AA_55AA, waits:0, exp_data:32'h0, exp_err:1'b1};
    vecs[5] = '{we:1'b1, dead:1'b0, addr:32'hFFFF_FFFC, sel:4'b1100, wdata:32'hA5A5_5A5A,
                rdata:32'h9999_9999, waits:2, exp_data:32'h0, exp_err:1'b0};
    vecs[6] = '{we:1'b0, dead:1'b0, addr:32'h8000_0000, sel:4'hF, wdata:32'h0,
                rdata:32'hFFFF_FFFF, waits:0, exp_data:32'hFFFF_FFFF, exp_err:1'b0};
    vb0 = '{we:1'b0, dead:1'b0, addr:32'h0000_0200, sel:4'hF, wdata:32'h0,
            rdata:32'h1111_2222, waits:0, exp_data:32'h1111_2222, exp_err:1'b0};
    vb1 = '{we:1'b0, dead:1'b0, addr:32'h0000_0204, sel:4'hF, wdata:32'h0,
            rdata:32'h3333_4444, waits:0, exp_data:32'h3333_4444, exp_err:1'b0};
    vfl = '{we:1'b1, dead:1'b0, addr:32'h0000_0024, sel:4'hF, wdata:32'h0F0F_F0F0,
            rdata:32'h0, waits:1, exp_data:32'h0, exp_err:1'b0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_flush = 1'b0;
    cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    slave_wait = 0; slave_dead = 1'b0; slave_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'(all_outs()), 128'(0));
    check("reset_stall", 128'(cpu_stall), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], 1'b0);
      @(posedge clk); #1;
    end

    // Back-to-back reads with request held through the completion cycle.
    run_txn(vb0, 1'b1);
    run_txn(vb1, 1'b0);
    @(posedge clk); #1;

    // Flush in the first BUSY cycle; the slave's late ack lands in ABORT.
    slave_wait = 0; slave_dead = 1'b0; slave_rdata = 32'h0BAD_0BAD;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_sel = 4'hF;
    @(negedge clk);
    check("flush_c0_stall", 128'(cpu_stall), 128'(1));
    @(posedge clk); #1;
    cpu_flush = 1'b1;
    @(negedge clk);
    check("flush_c1_cyc", 128'(wb_bus.wishbone_cyc_o), 128'(1));
    check("flush_c1_stall", 128'(cpu_stall), 128'(0));
    @(posedge clk); #1;
    cpu_flush = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("flush_abort_cyc", 128'(wb_bus.wishbone_cyc_o), 128'(0));
    check("flush_abort_stb", 128'(wb_bus.wishbone_stb_o), 128'(0));
    check("flush_abort_ready", 128'(cpu_ready), 128'(0));
    @(posedge clk); #1;
    run_txn(vfl, 1'b0);
    @(posedge clk); #1;

    // Reset while BUSY in the same cycle the slave acks.
    slave_wait = 0; slave_dead = 1'b0; slave_rdata = 32'h7777_8888;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0030; cpu_sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("rst_pre_cyc", 128'(wb_bus.wishbone_cyc_o), 128'(1));
    @(negedge clk);
    check("rst_mid_outputs", 128'(all_outs()), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_post_cyc", 128'(wb_bus.wishbone_cyc_o), 128'(0));
    check("sb_drain", 128'(sb_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
